vect_acc_stage: RTL and testbench

VECT_ACC_STAGE -- requirements
Module: vect_acc_stage

---
 rtl/vect_acc_stage.sv | 132 +++++++++++++
 tb/tb_vect_acc_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vect_acc_stage.sv
// Per-lane frame accumulator with one-deep result hold and a valid/ready handshake on both sides.
// Build option: define VACC_SAT_EN to clamp lane results to N bits instead of wrapping.

module vect_acc_lane #(
    parameter int N     = 8,
    parameter int ACC_W = N + 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         take,
    input  logic         first,
    input  logic [N-1:0] din,
    output logic [N-1:0] res,
    output logic         sat
);
    localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    // The first beat of a frame discards whatever the previous frame left behind.
    always_comb begin
        acc_next = (first ? '0 : acc) + {{(ACC_W-N){din[N-1]}}, din};
    end

    always_ff @(posedge clk) begin
        if (rst)       acc <= '0;
        else if (take) acc <= acc_next;
    end

`ifdef VACC_SAT_EN
    always_comb begin
        res = acc_next[N-1:0];
        sat = 1'b0;
        if ($signed(acc_next) > $signed(SMAX)) begin
            res = SMAX[N-1:0];
            sat = 1'b1;
        end else if ($signed(acc_next) < $signed(SMIN)) begin
            res = SMIN[N-1:0];
            sat = 1'b1;
        end
    end
`else
    always_comb begin
        res = acc_next[N-1:0];
        sat = 1'b0;
    end
`endif

endmodule

module vect_acc_stage #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int ACC_W = N + 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:M-1][N-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:M-1][N-1:0]   out_data,
    output logic [M-1:0]          out_sat,
    output logic [7:0]            out_count
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state;
    logic                 first;
    logic [7:0]           cnt;
    logic                 take;
    logic [7:0]           cnt_next;
    logic [0:M-1][N-1:0]  lane_res;
    logic [M-1:0]         lane_sat;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign take      = in_valid && (state == ACCUM);

    always_comb begin
        if (first)            cnt_next = 8'd1;
        else if (cnt == 8'hFF) cnt_next = cnt;
        else                  cnt_next = cnt + 8'd1;
    end

    for (genvar i = 0; i < M; i++) begin : g_lane
        vect_acc_lane #(.N(N), .ACC_W(ACC_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .take  (take),
            .first (first),
            .din   (in_data[i]),
            .res   (lane_res[i]),
            .sat   (lane_sat[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            first     <= 1'b1;
            cnt       <= '0;
            out_data  <= '0;
            out_sat   <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ACCUM: if (take) begin
                    cnt   <= cnt_next;
                    first <= in_last;
                    if (in_last) begin
                        out_data  <= lane_res;
                        out_sat   <= lane_sat;
                        out_count <= cnt_next;
                        state     <= HOLD;
                    end
                end
                // Result stays frozen until the consumer takes it; input is stalled meanwhile.
                HOLD: if (out_ready) begin
                    first <= 1'b1;
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_vect_acc_stage.sv
// Directed bench for vect_acc_stage (N=8, M=4, ACC_W=16); expectations follow VACC_SAT_EN.

module tb_vect_acc_stage;
    localparam int N = 8;
    localparam int M = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [0:M-1][N-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [0:M-1][N-1:0] out_data;
    logic [M-1:0]        out_sat;
    logic [7:0]          out_count;

    int errs = 0;
    int checks = 0;

    vect_acc_stage #(.N(N), .M(M), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

`ifdef VACC_SAT_EN
    localparam logic [7:0] EXP_L1   = 8'h7F;
    localparam logic [7:0] EXP_L2   = 8'h80;
    localparam logic [3:0] EXP_SAT  = 4'b0110;
    localparam logic [7:0] EXP_LONG = 8'h7F;
    localparam logic [3:0] EXP_LSAT = 4'b1000;
`else
    localparam logic [7:0] EXP_L1   = 8'hC8;
    localparam logic [7:0] EXP_L2   = 8'h38;
    localparam logic [3:0] EXP_SAT  = 4'b0000;
    localparam logic [7:0] EXP_LONG = 8'h2C;
    localparam logic [3:0] EXP_LSAT = 4'b0000;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] d0, input logic [N-1:0] d1,
                        input logic [N-1:0] d2, input logic [N-1:0] d3, input logic last);
        in_valid   = 1'b1;
        in_data[0] = d0;
        in_data[1] = d1;
        in_data[2] = d2;
        in_data[3] = d3;
        in_last    = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++;
        if (out_data !== '0 || out_sat !== 4'b0 || out_count !== 8'd0) begin
            errs++;
            $display("FAIL reset_outputs data=%h sat=%b count=%0d exp all zero", out_data, out_sat, out_count);
        end
    endtask

    task automatic test_accum();
        // Ready from the consumer must be ignored while accumulating.
        out_ready = 1'b1;
        send(8'd10, 8'd100, 8'h9C, 8'd0, 1'b0);
        tick();
        send(8'd20, 8'd100, 8'h9C, 8'd0, 1'b0);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL accum_mid_state out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
        end
        send(8'd30, 8'd0, 8'd0, 8'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin errs++; $display("FAIL accum_latency out_valid=%0b exp=1", out_valid); end
        checks++;
        if (out_data[0] !== 8'd60) begin errs++; $display("FAIL accum_lane0 got=%0d exp=60", out_data[0]); end
        checks++;
        if (out_data[1] !== EXP_L1) begin errs++; $display("FAIL accum_lane1 got=%h exp=%h", out_data[1], EXP_L1); end
        checks++;
        if (out_data[2] !== EXP_L2) begin errs++; $display("FAIL accum_lane2 got=%h exp=%h", out_data[2], EXP_L2); end
        checks++;
        if (out_data[3] !== 8'd0) begin errs++; $display("FAIL accum_lane3 got=%h exp=00", out_data[3]); end
        checks++;
        if (out_sat !== EXP_SAT) begin errs++; $display("FAIL accum_sat got=%b exp=%b", out_sat, EXP_SAT); end
        checks++;
        if (out_count !== 8'd3) begin errs++; $display("FAIL accum_count got=%0d exp=3", out_count); end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL accum_release out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_hold();
        send(8'd7, 8'd0, 8'd0, 8'd0, 1'b1);
        in_valid   = 1'b1;
        in_data[0] = 8'd50;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data[0] !== 8'd7 || out_count !== 8'd1) begin
                errs++;
                $display("FAIL hold_stable cyc=%0d valid=%0b ready=%0b d0=%0d cnt=%0d exp 1/0/7/1",
                         k, out_valid, in_ready, out_data[0], out_count);
            end
        end
        // in_valid still high across the release edge: that beat must not be taken.
        handshake();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL hold_release out_valid=%0b exp=0", out_valid); end
        send(8'd3, 8'd0, 8'd0, 8'd0, 1'b1);
        checks++;
        if (out_data[0] !== 8'd3 || out_count !== 8'd1) begin
            errs++;
            $display("FAIL hold_next_frame d0=%0d cnt=%0d exp 3/1", out_data[0], out_count);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        send(8'd9, 8'd0, 8'd0, 8'd0, 1'b0);
        send(8'd9, 8'd0, 8'd0, 8'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_state in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
        end
        send(8'd5, 8'd0, 8'd0, 8'd0, 1'b1);
        checks++;
        if (out_data[0] !== 8'd5 || out_count !== 8'd1 || out_valid !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_frame d0=%0d cnt=%0d valid=%0b exp 5/1/1", out_data[0], out_count, out_valid);
        end
        // Reset while holding drops the pending result.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== 8'd0) begin
            errs++;
            $display("FAIL rsthold valid=%0b data=%h cnt=%0d exp 0/0/0", out_valid, out_data, out_count);
        end
    endtask

    task automatic test_long();
        for (int k = 0; k < 300; k++) send(8'd0, 8'd0, 8'd0, 8'd1, (k == 299));
        checks++;
        if (out_count !== 8'd255) begin errs++; $display("FAIL long_count got=%0d exp=255", out_count); end
        checks++;
        if (out_data[3] !== EXP_LONG) begin errs++; $display("FAIL long_lane3 got=%h exp=%h", out_data[3], EXP_LONG); end
        checks++;
        if (out_sat !== EXP_LSAT) begin errs++; $display("FAIL long_sat got=%b exp=%b", out_sat, EXP_LSAT); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_accum();
        test_hold();
        test_reset_mid();
        test_long();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
